// File: rtl/spi_byte_engine_pkg.sv
// spi_byte_engine shared types and constants.
// States, default half-periods and the half-period selector.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  localparam int SPI_SLOW_HALF = 64;
  localparam int SPI_FAST_HALF = 1;

  function automatic int half_sel(
    input logic speed,
    input int   slow,
    input int   fast
  );
    return speed ? fast : slow;
  endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// Toggle req/ack byte interface between the MMC64
// register block (master) and the SPI engine (slave).
interface spi_byte_engine_if;
  import spi_pkg::*;

  logic       spi_req;
  logic [7:0] spi_d;
  logic       spi_speed;
  logic       spi_ack;
  logic [7:0] spi_q;
  logic       busy;

  modport master (
    output spi_req, spi_d, spi_speed,
    input  spi_ack, spi_q, busy
  );

  modport slave (
    input  spi_req, spi_d, spi_speed,
    output spi_ack, spi_q, busy
  );

endinterface

// File: rtl/spi_byte_engine_half_timer.sv
// SCK half-period down-counter; expire is high at zero.
// Loads on request, otherwise counts down and holds at zero.
module spi_half_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  import spi_pkg::*;

  logic [W-1:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (load) begin
      div <= load_val;
    end else if (div != '0) begin
      div <= div - W'(1);
    end
  end

  assign expire = (div == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte shifter, MSB first.
// One byte per spi_req toggle, answered by a spi_ack toggle.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int SLOW_HALF = SPI_SLOW_HALF,
  parameter int FAST_HALF = SPI_FAST_HALF
) (
  input  logic               clk,
  input  logic               reset,
  spi_byte_engine_if.slave   bus,
  output logic               sck,
  output logic               mosi,
  input  logic               miso
);

  localparam int HW = $clog2(SLOW_HALF) + 1;

  state_t        state, state_n;
  logic          pend;
  logic          start, rise, fall, done;
  logic          tmr_load, expire;
  logic [HW-1:0] half_r, half_new, load_val;
  logic [7:0]    tx, rx, q_r;
  logic [2:0]    bitc;
  logic          ack_r, busy_r;

  assign pend     = bus.spi_req ^ ack_r;
  assign half_new = HW'(half_sel(bus.spi_speed,
                                 SLOW_HALF, FAST_HALF));
  assign load_val = (start ? half_new : half_r) - HW'(1);

  spi_half_timer #(.W(HW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    done     = 1'b0;
    tmr_load = 1'b0;
    unique case (state)
      IDLE: if (pend) begin
        start    = 1'b1;
        tmr_load = 1'b1;
        state_n  = LOW;
      end
      LOW: if (expire) begin
        rise     = 1'b1;
        tmr_load = 1'b1;
        state_n  = HIGH;
      end
      HIGH: if (expire) begin
        fall = 1'b1;
        if (bitc == 3'd7) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_load = 1'b1;
          state_n  = LOW;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx rotates so mosi always comes from the top bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck    <= 1'b0;
      mosi   <= 1'b1;
      busy_r <= 1'b0;
      ack_r  <= 1'b0;
      q_r    <= 8'hFF;
      tx     <= '0;
      rx     <= '0;
      bitc   <= '0;
      half_r <= '0;
    end else begin
      if (start) begin
        tx     <= bus.spi_d;
        mosi   <= bus.spi_d[7];
        half_r <= half_new;
        bitc   <= '0;
        busy_r <= 1'b1;
      end
      if (rise) begin
        sck <= 1'b1;
        rx  <= {rx[6:0], miso};
      end
      if (fall) begin
        sck <= 1'b0;
        if (done) begin
          q_r    <= rx;
          ack_r  <= ~ack_r;
          busy_r <= 1'b0;
          mosi   <= 1'b1;
        end else begin
          tx   <= {tx[6:0], tx[7]};
          mosi <= tx[6];
          bitc <= bitc + 3'd1;
        end
      end
    end
  end

  assign bus.spi_ack = ack_r;
  assign bus.spi_q   = q_r;
  assign bus.busy    = busy_r;

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
- SPI master byte shifter: the far end of the toggle req/ack byte interface that the MMC64 register block drives.
- Accepts one byte per request toggle, shifts it out MSB-first in SPI mode 0 while shifting in MISO, then returns the received byte with an ack toggle.
- Sits between the MMC64 register block and the SD card pins. Chip select is owned by the register block and does not pass through this block.

Parameters:
- SLOW_HALF, 64, SCK half-period in clk cycles when spi_speed=0 (init rate, ≤400 kHz); must be ≥1.
- FAST_HALF, 1, SCK half-period in clk cycles when spi_speed=1; must be ≥1 and ≤SLOW_HALF.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- spi_req  in  1  request toggle; a transfer is pending while spi_req != spi_ack.
- spi_d  in  8  byte to transmit; stable whenever a request is pending.
- spi_speed  in  1  0 = SLOW_HALF, 1 = FAST_HALF; sampled at transfer start.
- spi_ack  out  1  acknowledge toggle; flips once per completed byte.
- spi_q  out  8  last received byte; valid no later than the edge on which spi_ack flips.
- sck  out  1  SPI clock, idle low.
- mosi  out  1  master out, MSB first.
- miso  in  1  master in.
- busy  out  1  high while a transfer is in progress.

Behaviour:
- Reset (async assert, sync release) drives: spi_ack=0, spi_q=8'hFF, sck=0, mosi=1, busy=0, state=IDLE, counters=0.
- States:
  - IDLE: on a clk edge with spi_req^spi_ack=1:
    - load tx shift register with spi_d, and mosi<=spi_d[7];
    - latch half = spi_speed ? FAST_HALF : SLOW_HALF;
    - div<=half-1, bit<=0, busy<=1, go to LOW.
  - LOW (sck=0): while div≠0, decrement div. At div=0:
    - sck<=1, and rx<={rx[6:0],miso} (sample on the rising SCK edge);
    - div<=half-1, go to HIGH.
  - HIGH (sck=1): while div≠0, decrement div. At div=0, sck<=0, then:
    - if bit=7: spi_q<=rx value including the bit just sampled, spi_ack<=~spi_ack, busy<=0, mosi<=1, go to IDLE;
    - else: mosi<=next tx bit, bit<=bit+1, div<=half-1, go to LOW.
- Timing: with the request detected at edge T0:
  - rising SCK edges at T0+(2k+1)·half, falling edges at T0+(2k+2)·half, for k=0..7;
  - the ack flip and spi_q update occur at T0+16·half, on the same edge as the final SCK fall.
  - Total latency is 16·half+1 cycles from a req toggle registered on the edge before T0.
- Back-to-back: a new toggle is accepted on the first IDLE edge after the ack flip. There are no dead cycles beyond the IDLE detect edge.
- spi_speed and spi_d changes during a transfer are ignored; both are latched at start.
- Protocol rule: the requester toggles spi_req only when spi_req==spi_ack. A double toggle during a transfer is a protocol violation; the engine does not detect it and completes the current byte.
- Reset mid-transfer: SCK drops low immediately and the partial byte is discarded. spi_ack returns to 0, so the requester must re-align its req to ack on its own reset.
- div width: $clog2(SLOW_HALF)+1. bit width: 3.
- MISO is sampled directly, with no synchroniser. The card drives MISO from the falling SCK edge, which is at least one clk before the sample.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, LOW, HIGH};
  - default constants SPI_SLOW_HALF=64, SPI_FAST_HALF=1;
  - function half_sel(speed).
- One sub-module: spi_half_timer (loadable down-counter that outputs expire at div=0). The FSM and shift registers stay in spi_byte_engine.

Test Plan:
- Reset: hold reset low, toggle spi_req -> spi_ack=0, spi_q=FF, sck=0, mosi=1, busy=0, and no SCK edges.
- Fast byte, FAST_HALF=1: spi_d=A5, speed=1, card model returns 3C -> mosi shows 1,0,1,0,0,1,0,1 on rising edges; spi_q=3C; spi_ack flips exactly 16 cycles after T0.
- Slow byte, SLOW_HALF=4: spi_d=00, miso held 1 -> 8 SCK pulses each 4 high/4 low; spi_q=FF; ack at T0+64.
- Back-to-back: two requests 81 then 7E issued immediately after each ack -> two acks; the second transfer's first rising SCK occurs half+1 cycles after the first ack; received bytes match the model.
- Speed/data change mid-transfer: flip spi_speed and spi_d after bit 3 -> timing and transmitted bits unchanged for the current byte.
- Reset mid-transfer: assert reset after 5 SCK pulses -> sck=0 asynchronously, spi_ack=0, spi_q=FF; after release and requester re-align, a new byte C3 completes correctly.
